// File: rtl/m_ram_loader_pkg.sv
// m_ram_loader_pkg: shared types and constants for the SPRAM loader.
// Optional read-back verify is compiled in with M_RAM_LOADER_VERIFY_EN.
package m_ram_loader_pkg;

  localparam int ADRW_DEF = 17;
  localparam int LANE_W   = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WRITE = 3'd2,
    S_GAP   = 3'd3,
`ifdef M_RAM_LOADER_VERIFY_EN
    S_VERIFY = 3'd4,
`endif
    S_FIN   = 3'd5
  } state_t;

  // Expand a 4-bit byte-lane select into a 32-bit data mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/m_ram_loader_packer.sv
// m_byte_packer: packs bytes little-endian into a 32-bit word and tracks
// which byte lanes hold data. o_full flags that the byte being written
// lands in the top lane, so the word is complete after this edge.
module m_byte_packer
  import m_ram_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_wr,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_data,
  output logic [3:0]  o_sel,
  output logic        o_full
);

  logic [LANE_W-1:0] r_lane;
  logic [31:0]       r_data;
  logic [3:0]        r_sel;

  // Lane counter, data word and lane selects; clear wins over a write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lane <= '0;
      r_data <= '0;
      r_sel  <= '0;
    end else if (i_clr) begin
      r_lane <= '0;
      r_data <= '0;
      r_sel  <= '0;
    end else if (i_wr) begin
      r_data[{r_lane, 3'b000} +: 8] <= i_byte;
      r_sel[r_lane]                 <= 1'b1;
      r_lane                        <= r_lane + 1'b1;
    end
  end

  assign o_data = r_data;
  assign o_sel  = r_sel;
  assign o_full = i_wr & (&r_lane);

endmodule

// File: rtl/m_ram_loader.sv
// m_ram_loader: Wishbone-classic initiator that streams bytes into RAM as
// single-beat 32-bit writes. Defining M_RAM_LOADER_VERIFY_EN adds a
// read-back of every written word that sets the sticky err flag on any
// mismatch in the selected lanes.
module m_ram_loader
  import m_ram_loader_pkg::*;
#(
  parameter int ADRW = ADRW_DEF
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic            start,
  input  logic [ADRW-1:0] base,
  input  logic [ADRW:0]   nbytes,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            byte_ready,
  output logic            STB_O,
  output logic            WE_O,
  output logic [3:0]      SEL_O,
  output logic [ADRW-1:0] ADR_O,
  output logic [31:0]     DAT_O,
  input  logic [31:0]     DAT_I,
  input  logic            ACK_I,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_t          r_state;
  logic            r_stb;
  logic            r_we;
  logic [ADRW-1:0] r_adr;
  logic [ADRW:0]   r_rem;
  logic            r_rdy;
  logic            r_busy;
  logic            r_done;
  logic            r_vph;   // set while the current word is in its read-back phase

  logic            w_acc;
  logic            w_full;
  logic            w_last;
  logic            w_adv;
  logic            w_clr;
  logic [31:0]     w_dat;
  logic [3:0]      w_sel;
  logic            w_unused;

  assign w_acc  = byte_valid & r_rdy;
  assign w_last = (r_rem == {{ADRW{1'b0}}, 1'b1});

`ifdef M_RAM_LOADER_VERIFY_EN
  logic r_err;
  logic w_mis;

  // A GAP only advances once the word has also been read back.
  assign w_adv    = (r_state == S_GAP) & r_vph;
  assign w_mis    = |((DAT_I ^ w_dat) & lane_mask(w_sel));
  assign err      = r_err;
  assign w_unused = ^base[1:0];
`else
  assign w_adv    = (r_state == S_GAP);
  assign err      = 1'b0;
  assign w_unused = ^{DAT_I, base[1:0]};
`endif

  // Packer is cleared when a load is accepted and after each finished word.
  assign w_clr = (((r_state == S_IDLE) || (r_state == S_FIN)) & start) | w_adv;

  m_byte_packer u_packer (
    .i_clk  (CLK_I),
    .i_rst  (RST_I),
    .i_clr  (w_clr),
    .i_wr   (w_acc),
    .i_byte (byte_data),
    .o_data (w_dat),
    .o_sel  (w_sel),
    .o_full (w_full)
  );

  // Loader FSM; all bus and handshake outputs are registered here.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state <= S_IDLE;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_rem   <= '0;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_vph   <= 1'b0;
`ifdef M_RAM_LOADER_VERIFY_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // FIN behaves like IDLE for an incoming start so a start coincident
        // with done is not lost.
        S_IDLE, S_FIN: begin
          if (start) begin
            r_adr  <= {base[ADRW-1:2], 2'b00};
            r_rem  <= nbytes;
            r_busy <= 1'b1;
            r_vph  <= 1'b0;
`ifdef M_RAM_LOADER_VERIFY_EN
            r_err  <= 1'b0;
`endif
            if (nbytes == '0) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FILL;
              r_rdy   <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_FILL: begin
          if (w_acc) begin
            r_rem <= r_rem - 1'b1;
            if (w_full || w_last) begin
              r_state <= S_WRITE;
              r_rdy   <= 1'b0;
              r_stb   <= 1'b1;
              r_we    <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (ACK_I) begin
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (w_adv) begin
            r_adr <= r_adr + ADRW'(4);
            r_vph <= 1'b0;
            if (r_rem != '0) begin
              r_state <= S_FILL;
              r_rdy   <= 1'b1;
            end else begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end
          end
`ifdef M_RAM_LOADER_VERIFY_EN
          else begin
            r_state <= S_VERIFY;
            r_stb   <= 1'b1;
            r_we    <= 1'b0;
            r_vph   <= 1'b1;
          end
`endif
        end
`ifdef M_RAM_LOADER_VERIFY_EN
        S_VERIFY: begin
          if (ACK_I) begin
            if (w_mis) r_err <= 1'b1;
            r_stb   <= 1'b0;
            r_state <= S_GAP;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_stb   <= 1'b0;
          r_we    <= 1'b0;
          r_rdy   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign STB_O      = r_stb;
  assign WE_O       = r_we;
  assign ADR_O      = r_adr;
  assign DAT_O      = w_dat;
  assign SEL_O      = w_sel;
  assign byte_ready = r_rdy;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_m_ram_loader.sv
// tb_m_ram_loader: directed bench for m_ram_loader with a small Wishbone
// responder (combinational write ACK, read ACK two cycles after strobe).
module tb_m_ram_loader;

`ifdef M_RAM_LOADER_VERIFY_EN
  localparam int VX = 4;
`else
  localparam int VX = 0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [16:0] base;
  logic [17:0] nbytes;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, STB_O, WE_O, busy, done, err;
  logic [3:0]  SEL_O;
  logic [16:0] ADR_O;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic        ACK_I;

  logic        wr_ack_en;
  logic        corrupt;
  logic [31:0] last_wr;
  logic [1:0]  rd_cnt;
  logic [16:0] q_adr[$];
  logic [31:0] q_dat[$];
  logic [3:0]  q_sel[$];
  logic [7:0]  stim[16];

  int n_checks;
  int n_errs;

  m_ram_loader dut (
    .CLK_I(clk), .RST_I(rst), .start(start), .base(base), .nbytes(nbytes),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .STB_O(STB_O), .WE_O(WE_O), .SEL_O(SEL_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
    .DAT_I(DAT_I), .ACK_I(ACK_I), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    ACK_I = STB_O & (WE_O ? wr_ack_en : (rd_cnt == 2'd2));
    DAT_I = last_wr ^ (corrupt ? 32'h00FF_0000 : 32'h0);
  end

  always @(posedge clk) begin
    if (STB_O && ACK_I && WE_O) begin
      q_adr.push_back(ADR_O);
      q_dat.push_back(DAT_O);
      q_sel.push_back(SEL_O);
      last_wr <= DAT_O;
    end
    if (STB_O && !WE_O && !ACK_I) rd_cnt <= rd_cnt + 2'd1;
    else rd_cnt <= 2'd0;
  end

  initial begin
    #200us;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_adr.delete();
    q_dat.delete();
    q_sel.delete();
  endtask

  // Issues a start and streams stim[] until done; done_tick is the number
  // of cycles after the start edge at which done is seen (-1 on timeout).
  task automatic run_load(input logic [16:0] b, input logic [17:0] n, input bit toggle,
                          input int restart_at, output int done_tick);
    int  idx;
    bit  acc;
    idx       = 0;
    done_tick = -1;
    base      = b;
    nbytes    = n;
    start     = 1'b1;
    for (int t = 1; t <= 300; t++) begin
      acc = byte_valid & byte_ready;
      tick();
      if (acc) idx++;
      start = (t == restart_at);
      if (start) begin
        base   = 17'h00300;
        nbytes = 18'd2;
      end
      byte_valid = (idx < int'(n)) && (!toggle || (t % 2 == 0));
      byte_data  = stim[idx];
      if (done) begin
        done_tick = t;
        break;
      end
    end
    start      = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (STB_O !== 1'b0) begin n_errs++; $display("FAIL reset_stb got=%b exp=0", STB_O); end
    n_checks++; if (WE_O !== 1'b0) begin n_errs++; $display("FAIL reset_we got=%b exp=0", WE_O); end
    n_checks++; if (SEL_O !== 4'h0) begin n_errs++; $display("FAIL reset_sel got=%h exp=0", SEL_O); end
    n_checks++; if (ADR_O !== 17'h0) begin n_errs++; $display("FAIL reset_adr got=%h exp=0", ADR_O); end
    n_checks++; if (DAT_O !== 32'h0) begin n_errs++; $display("FAIL reset_dat got=%h exp=0", DAT_O); end
    n_checks++; if (byte_ready !== 1'b0) begin n_errs++; $display("FAIL reset_ready got=%b exp=0", byte_ready); end
    n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errs++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (err !== 1'b0) begin n_errs++; $display("FAIL reset_err got=%b exp=0", err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_two_words();
    int dt;
    clear_q();
    for (int i = 0; i < 8; i++) stim[i] = 8'(i + 1);
    run_load(17'h00100, 18'd8, 1'b0, -1, dt);
    n_checks++; if (dt !== 13 + 2 * VX) begin n_errs++; $display("FAIL two_done_tick got=%0d exp=%0d", dt, 13 + 2 * VX); end
    n_checks++; if (err !== 1'b0) begin n_errs++; $display("FAIL two_err got=%b exp=0", err); end
    n_checks++; if (q_adr.size() !== 2) begin n_errs++; $display("FAIL two_count got=%0d exp=2", q_adr.size()); end
    n_checks++; if (q_adr[0] !== 17'h00100) begin n_errs++; $display("FAIL two_adr0 got=%h exp=00100", q_adr[0]); end
    n_checks++; if (q_dat[0] !== 32'h0403_0201) begin n_errs++; $display("FAIL two_dat0 got=%h exp=04030201", q_dat[0]); end
    n_checks++; if (q_sel[0] !== 4'hF) begin n_errs++; $display("FAIL two_sel0 got=%h exp=f", q_sel[0]); end
    n_checks++; if (q_adr[1] !== 17'h00104) begin n_errs++; $display("FAIL two_adr1 got=%h exp=00104", q_adr[1]); end
    n_checks++; if (q_dat[1] !== 32'h0807_0605) begin n_errs++; $display("FAIL two_dat1 got=%h exp=08070605", q_dat[1]); end
    n_checks++; if (q_sel[1] !== 4'hF) begin n_errs++; $display("FAIL two_sel1 got=%h exp=f", q_sel[1]); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_errs++; $display("FAIL two_done_pulse got=%b exp=0", done); end
    n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL two_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_wrap();
    int dt;
    clear_q();
    stim[0] = 8'hA1; stim[1] = 8'hA2; stim[2] = 8'hA3; stim[3] = 8'hA4; stim[4] = 8'hA5;
    run_load(17'h1FFFE, 18'd5, 1'b0, -1, dt);
    n_checks++; if (dt !== 10 + 2 * VX) begin n_errs++; $display("FAIL wrap_done_tick got=%0d exp=%0d", dt, 10 + 2 * VX); end
    n_checks++; if (q_adr.size() !== 2) begin n_errs++; $display("FAIL wrap_count got=%0d exp=2", q_adr.size()); end
    n_checks++; if (q_adr[0] !== 17'h1FFFC) begin n_errs++; $display("FAIL wrap_adr0 got=%h exp=1fffc", q_adr[0]); end
    n_checks++; if (q_dat[0] !== 32'hA4A3_A2A1) begin n_errs++; $display("FAIL wrap_dat0 got=%h exp=a4a3a2a1", q_dat[0]); end
    n_checks++; if (q_sel[0] !== 4'hF) begin n_errs++; $display("FAIL wrap_sel0 got=%h exp=f", q_sel[0]); end
    n_checks++; if (q_adr[1] !== 17'h00000) begin n_errs++; $display("FAIL wrap_adr1 got=%h exp=00000", q_adr[1]); end
    n_checks++; if (q_dat[1] !== 32'h0000_00A5) begin n_errs++; $display("FAIL wrap_dat1 got=%h exp=000000a5", q_dat[1]); end
    n_checks++; if (q_sel[1] !== 4'b0001) begin n_errs++; $display("FAIL wrap_sel1 got=%b exp=0001", q_sel[1]); end
    tick();
  endtask

  task automatic test_zero();
    clear_q();
    base   = 17'h00040;
    nbytes = 18'd0;
    start  = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b1) begin n_errs++; $display("FAIL zero_busy got=%b exp=1", busy); end
    n_checks++; if (done !== 1'b1) begin n_errs++; $display("FAIL zero_done got=%b exp=1", done); end
    n_checks++; if (STB_O !== 1'b0) begin n_errs++; $display("FAIL zero_stb got=%b exp=0", STB_O); end
    // start held high through the done cycle: must be accepted again
    tick();
    start = 1'b0;
    n_checks++; if (done !== 1'b1) begin n_errs++; $display("FAIL zero_restart_done got=%b exp=1", done); end
    n_checks++; if (busy !== 1'b1) begin n_errs++; $display("FAIL zero_restart_busy got=%b exp=1", busy); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL zero_busy_after got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errs++; $display("FAIL zero_done_after got=%b exp=0", done); end
    n_checks++; if (q_adr.size() !== 0) begin n_errs++; $display("FAIL zero_writes got=%0d exp=0", q_adr.size()); end
  endtask

  task automatic test_reset_mid();
    int  idx;
    int  done_seen;
    bit  acc;
    bit  seen_stb;
    clear_q();
    wr_ack_en = 1'b0;
    for (int i = 0; i < 4; i++) stim[i] = 8'(8'h50 + i);
    idx      = 0;
    seen_stb = 1'b0;
    base     = 17'h00080;
    nbytes   = 18'd4;
    start    = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      acc = byte_valid & byte_ready;
      tick();
      if (acc) idx++;
      start      = 1'b0;
      byte_valid = (idx < 4);
      byte_data  = stim[idx];
      if (STB_O) begin
        seen_stb = 1'b1;
        break;
      end
    end
    byte_valid = 1'b0;
    n_checks++; if (seen_stb !== 1'b1) begin n_errs++; $display("FAIL rstmid_stb_seen got=%b exp=1", seen_stb); end
    tick();
    tick();
    n_checks++; if (STB_O !== 1'b1) begin n_errs++; $display("FAIL rstmid_stb_held got=%b exp=1", STB_O); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (STB_O !== 1'b0) begin n_errs++; $display("FAIL rstmid_stb got=%b exp=0", STB_O); end
    n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_checks++; if (byte_ready !== 1'b0) begin n_errs++; $display("FAIL rstmid_ready got=%b exp=0", byte_ready); end
    tick();
    rst       = 1'b0;
    wr_ack_en = 1'b1;
    done_seen = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (done) done_seen++;
    end
    n_checks++; if (done_seen !== 0) begin n_errs++; $display("FAIL rstmid_no_done got=%0d exp=0", done_seen); end
    n_checks++; if (q_adr.size() !== 0) begin n_errs++; $display("FAIL rstmid_writes got=%0d exp=0", q_adr.size()); end
  endtask

  task automatic test_toggle_busy_start();
    int dt;
    clear_q();
    for (int i = 0; i < 6; i++) stim[i] = 8'(8'hB0 + i);
    run_load(17'h00200, 18'd6, 1'b1, 3, dt);
    n_checks++; if (dt !== 17 + 2 * VX) begin n_errs++; $display("FAIL tog_done_tick got=%0d exp=%0d", dt, 17 + 2 * VX); end
    n_checks++; if (q_adr.size() !== 2) begin n_errs++; $display("FAIL tog_count got=%0d exp=2", q_adr.size()); end
    n_checks++; if (q_adr[0] !== 17'h00200) begin n_errs++; $display("FAIL tog_adr0 got=%h exp=00200", q_adr[0]); end
    n_checks++; if (q_dat[0] !== 32'hB3B2_B1B0) begin n_errs++; $display("FAIL tog_dat0 got=%h exp=b3b2b1b0", q_dat[0]); end
    n_checks++; if (q_adr[1] !== 17'h00204) begin n_errs++; $display("FAIL tog_adr1 got=%h exp=00204", q_adr[1]); end
    n_checks++; if (q_dat[1] !== 32'h0000_B5B4) begin n_errs++; $display("FAIL tog_dat1 got=%h exp=0000b5b4", q_dat[1]); end
    n_checks++; if (q_sel[1] !== 4'b0011) begin n_errs++; $display("FAIL tog_sel1 got=%b exp=0011", q_sel[1]); end
    for (int t = 0; t < 6; t++) tick();
    n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL tog_idle_busy got=%b exp=0", busy); end
    n_checks++; if (q_adr.size() !== 2) begin n_errs++; $display("FAIL tog_no_extra got=%0d exp=2", q_adr.size()); end
  endtask

`ifdef M_RAM_LOADER_VERIFY_EN
  task automatic test_verify();
    int dt;
    clear_q();
    stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33; stim[3] = 8'h44;
    corrupt = 1'b1;
    run_load(17'h00040, 18'd4, 1'b0, -1, dt);
    n_checks++; if (dt !== 11) begin n_errs++; $display("FAIL ver_done_tick got=%0d exp=11", dt); end
    n_checks++; if (err !== 1'b1) begin n_errs++; $display("FAIL ver_err_at_done got=%b exp=1", err); end
    n_checks++; if (q_dat[0] !== 32'h4433_2211) begin n_errs++; $display("FAIL ver_dat got=%h exp=44332211", q_dat[0]); end
    corrupt = 1'b0;
    tick();
    n_checks++; if (err !== 1'b1) begin n_errs++; $display("FAIL ver_err_sticky got=%b exp=1", err); end
    nbytes = 18'd0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_errs++; $display("FAIL ver_err_clear got=%b exp=0", err); end
    tick();
  endtask
`endif

  initial begin
    n_checks   = 0;
    n_errs     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    base       = '0;
    nbytes     = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    wr_ack_en  = 1'b1;
    corrupt    = 1'b0;
    last_wr    = '0;
    rd_cnt     = '0;
    for (int i = 0; i < 16; i++) stim[i] = '0;
    #1;
    test_reset();
    test_two_words();
    test_wrap();
    test_zero();
    test_reset_mid();
    test_toggle_busy_start();
`ifdef M_RAM_LOADER_VERIFY_EN
    test_verify();
`endif
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
